// File: rtl/graph_pkg.sv
// graph_pkg: shared FSM encoding, tag layout and derived constants for worker_ctrl
package graph_pkg;
    localparam int DEF_Q = 16;
    localparam int DEF_VID_ADDR_SPACE = 4;
    localparam int DEF_SUB_BW = 4;
    localparam int DEF_PIPE_LAT = 4;
    localparam int ROWS = 1 << DEF_VID_ADDR_SPACE;
    localparam int NSUB = 1 << DEF_SUB_BW;
    localparam int DONE_CYCLES = ROWS * (2 + DEF_Q * NSUB) + DEF_PIPE_LAT + 1;
    typedef enum logic [2:0] {IDLE, RD_VID, LAT_VID, SCAN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic row_end;
        logic [3:0] q;
        logic [DEF_VID_ADDR_SPACE-1:0] row;
    } tag_t;
endpackage

// File: rtl/ctrl_tag_pipe.sv
// ctrl_tag_pipe: en-gated tag delay line with sync clear and in-flight flag
module ctrl_tag_pipe
    import graph_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  tag_t din,
    output tag_t dout,
    output logic pending
);
    tag_t stage [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign dout = stage[DEPTH-1];
    // The output stage is excluded so DRAIN exits while the last tag is being consumed.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage[i].valid;
    end
endmodule

// File: rtl/worker_ctrl.sv
// worker_ctrl: row/sub-batch sequencer feeding one partition worker
module worker_ctrl
    import graph_pkg::*;
#(
    parameter int Q = DEF_Q,
    parameter int VID_BW = 16,
    parameter int VID_ADDR_SPACE = DEF_VID_ADDR_SPACE,
    parameter int SUB_BW = DEF_SUB_BW,
    parameter int DIST_ADDR_SPACE = 16,
    parameter int LOC_ADDR_SPACE = 4,
    parameter int NEXT_ADDR_SPACE = 4,
    parameter int PRO_ADDR_SPACE = 4,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int BATCH_BW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       start,
    input  logic [BATCH_BW-1:0]        batch_num,
    input  logic [Q*VID_BW-1:0]        vid_rdata,
    output logic                       vid_ren,
    output logic [VID_ADDR_SPACE-1:0]  vid_raddr,
    output logic                       dist_ren,
    output logic [DIST_ADDR_SPACE-1:0] dist_raddr,
    output logic                       loc_ren,
    output logic [LOC_ADDR_SPACE-1:0]  loc_raddr,
    output logic                       acc_clr,
    output logic                       acc_en,
    output logic                       acc_last,
    output logic [3:0]                 acc_q,
    output logic                       next_wen,
    output logic [NEXT_ADDR_SPACE-1:0] next_waddr,
    output logic                       pro_wen,
    output logic [PRO_ADDR_SPACE-1:0]  pro_waddr,
    output logic [BATCH_BW-1:0]        cur_batch,
    output logic                       busy,
    output logic                       done
);
    state_t state, nxt;
    logic [VID_ADDR_SPACE-1:0] row;
    logic [3:0] q;
    logic [SUB_BW-1:0] sub;
    logic [VID_BW-1:0] vid [Q];
    logic last_issue, pending;
    tag_t tag_in, tag_out;
    assign last_issue = q == 4'(Q - 1) && sub == '1;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? RD_VID : IDLE;
            RD_VID:  nxt = LAT_VID;
            LAT_VID: nxt = SCAN;
            SCAN:    nxt = last_issue ? (row == '1 ? DRAIN : RD_VID) : SCAN;
            DRAIN:   nxt = pending ? DRAIN : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row <= '0;
            q <= '0;
            sub <= '0;
            cur_batch <= '0;
            vid <= '{default: '0};
        end else if (en) begin
            state <= nxt;
            if (state == IDLE && start) begin
                row <= '0;
                cur_batch <= batch_num;
            end
            if (state == LAT_VID) begin
                for (int i = 0; i < Q; i++) vid[i] <= vid_rdata[(Q-i)*VID_BW-1 -: VID_BW];
                q <= '0;
                sub <= '0;
            end
            if (state == SCAN) begin
                sub <= sub + 1'b1;
                if (sub == '1) q <= q + 1'b1;
                if (last_issue && row != '1) row <= row + 1'b1;
            end
        end
    end
    // Each issue carries enough context to drive the worker strobes and row commit later.
    always_comb begin
        tag_in = '0;
        tag_in.valid = state == SCAN;
        tag_in.first = sub == '0;
        tag_in.last = sub == '1;
        tag_in.row_end = last_issue;
        tag_in.q = q;
        tag_in.row = row;
    end
    ctrl_tag_pipe #(.DEPTH(PIPE_LAT)) u_pipe (
        .clk(clk),
        .rst(rst),
        .en(en),
        .din(tag_in),
        .dout(tag_out),
        .pending(pending)
    );
    assign vid_ren = en && state == RD_VID;
    assign vid_raddr = row;
    assign dist_ren = en && state == SCAN;
    assign loc_ren = dist_ren;
    assign dist_raddr = {vid[q][DIST_ADDR_SPACE-SUB_BW-1:0], sub};
    assign loc_raddr = sub;
    assign acc_en = en && tag_out.valid;
    assign acc_clr = acc_en && tag_out.first;
    assign acc_last = acc_en && tag_out.last;
    assign acc_q = tag_out.q;
    assign next_wen = acc_en && tag_out.row_end;
    assign pro_wen = next_wen;
    assign next_waddr = tag_out.row;
    assign pro_waddr = tag_out.row;
    assign busy = state != IDLE;
    assign done = en && state == DONE;
endmodule

// File: tb/tb_worker_ctrl.sv
// tb_worker_ctrl: scoreboard bench for worker_ctrl address, strobe and commit sequencing
module tb_worker_ctrl;
    logic clk = 0, rst = 1, en = 0, start = 0;
    logic [7:0] batch_num = '0;
    logic [255:0] vid_rdata, sram_q = '0, rnd_data = '0;
    bit rnd_mode = 0;
    logic vid_ren, dist_ren, loc_ren, acc_clr, acc_en, acc_last, next_wen, pro_wen, busy, done;
    logic [3:0] vid_raddr, loc_raddr, acc_q, next_waddr, pro_waddr;
    logic [15:0] dist_raddr;
    logic [7:0] cur_batch;
    logic any_strobe;
    worker_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .batch_num(batch_num),
        .vid_rdata(vid_rdata), .vid_ren(vid_ren), .vid_raddr(vid_raddr),
        .dist_ren(dist_ren), .dist_raddr(dist_raddr), .loc_ren(loc_ren), .loc_raddr(loc_raddr),
        .acc_clr(acc_clr), .acc_en(acc_en), .acc_last(acc_last), .acc_q(acc_q),
        .next_wen(next_wen), .next_waddr(next_waddr), .pro_wen(pro_wen), .pro_waddr(pro_waddr),
        .cur_batch(cur_batch), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    assign vid_rdata = rnd_mode ? rnd_data : sram_q;
    assign any_strobe = vid_ren | dist_ren | loc_ren | acc_en | acc_clr | acc_last | next_wen | pro_wen | done;
    // Row r holds vid[q] = 0x0010 + q + 0x0100*r
    function automatic logic [255:0] row_word(input int r);
        logic [255:0] w = '0;
        for (int k = 0; k < 16; k++) w[(16-k)*16-1 -: 16] = 16'(16'h0010 + k + 16'h0100 * r);
        return w;
    endfunction
    always @(posedge clk) if (vid_ren) sram_q <= row_word(int'(vid_raddr));
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int total = 0, bad = 0;
    logic [15:0] q_dist [$];
    logic [5:0] q_acc [$];
    logic [3:0] q_com [$];
    int exp_done = -1, exp_fd = -1, exp_fa = -1, done_cyc = -1;
    bit done_seen = 0;
    logic [15:0] e16;
    logic [5:0] e6;
    logic [3:0] e4;
    task automatic chk(input string n, input longint a, input longint e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) if (!rst) begin
        if (!en) chk("stall_strobes", any_strobe, 0);
        if (dist_ren) begin
            if (exp_fd >= 0) begin
                chk("first_dist_cyc", cyc, exp_fd);
                exp_fd = -1;
            end
            if (q_dist.size() == 0) chk("dist_unexpected", 1, 0);
            else begin
                e16 = q_dist.pop_front();
                chk("dist_raddr", dist_raddr, e16);
                chk("loc_raddr", loc_raddr, e16[3:0]);
                chk("loc_ren", loc_ren, 1);
            end
        end
        if (acc_en) begin
            if (exp_fa >= 0) begin
                chk("first_acc_cyc", cyc, exp_fa);
                exp_fa = -1;
            end
            if (q_acc.size() == 0) chk("acc_unexpected", 1, 0);
            else begin
                e6 = q_acc.pop_front();
                chk("acc_clr_last_q", {acc_clr, acc_last, acc_q}, e6);
            end
        end else if (acc_clr | acc_last) chk("acc_orphan", 1, 0);
        if (next_wen | pro_wen) begin
            chk("commit_pair", {next_wen, pro_wen}, 2'b11);
            if (q_com.size() == 0) chk("commit_unexpected", 1, 0);
            else begin
                e4 = q_com.pop_front();
                chk("next_waddr", next_waddr, e4);
                chk("pro_waddr", pro_waddr, e4);
            end
        end
        if (done) begin
            chk("done_cyc", cyc, exp_done);
            chk("busy_at_done", busy, 1);
            done_seen = 1;
            done_cyc = cyc;
        end else if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_after_done", busy, 0);
    end
    task automatic start_run(input logic [7:0] b, input bit stall);
        int n = cyc;
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++)
                for (int s = 0; s < 16; s++) begin
                    q_dist.push_back(16'((16'h0010 + k + 16'h0100 * r) * 16 + s));
                    q_acc.push_back({s == 0, s == 15, 4'(k)});
                end
            q_com.push_back(4'(r));
        end
        exp_fd = n + 3;
        exp_fa = n + 7;
        exp_done = n + (stall ? 4143 : 4133);
        done_seen = 0;
        done_cyc = -1;
        start = 1;
        batch_num = b;
        step();
        start = 0;
        batch_num = 8'hEE;
        chk("cur_batch", cur_batch, b);
    endtask
    task automatic wait_done();
        int k = 0;
        while (!done_seen && k < 6000) begin
            step();
            k++;
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        step();
        step();
        chk("queues_drained", q_dist.size() + q_acc.size() + q_com.size(), 0);
    endtask
    initial begin
        rnd_mode = 1;
        for (int i = 0; i < 3; i++) begin
            en = 1'($urandom);
            start = 1'($urandom);
            batch_num = 8'($urandom);
            rnd_data = {8{$urandom}};
            step();
        end
        chk("rst_vid", {vid_ren, vid_raddr}, 0);
        chk("rst_dist", {dist_ren, dist_raddr}, 0);
        chk("rst_loc", {loc_ren, loc_raddr}, 0);
        chk("rst_acc", {acc_clr, acc_en, acc_last, acc_q}, 0);
        chk("rst_commit", {next_wen, next_waddr, pro_wen, pro_waddr}, 0);
        chk("rst_batch", cur_batch, 0);
        chk("rst_busy_done", {busy, done}, 0);
        rst = 0;
        rnd_mode = 0;
        en = 1;
        start = 0;
        repeat (10) begin
            step();
            chk("idle_strobes", any_strobe, 0);
            chk("idle_busy", busy, 0);
        end
        start_run(8'h05, 0);
        wait_done();
        start_run(8'h33, 1);
        repeat (117) step();
        en = 0;
        repeat (10) begin
            step();
            chk("stall_addr_hold", dist_raddr, 16'h0173);
        end
        en = 1;
        wait_done();
        start_run(8'h77, 0);
        repeat (100) step();
        start = 1;
        batch_num = 8'hAA;
        step();
        start = 0;
        chk("ignored_start_batch", cur_batch, 8'h77);
        chk("ignored_start_busy", busy, 1);
        repeat (500) step();
        rst = 1;
        step();
        q_dist.delete();
        q_acc.delete();
        q_com.delete();
        exp_done = -1;
        exp_fd = -1;
        exp_fa = -1;
        done_cyc = -1;
        rst = 0;
        repeat (300) begin
            step();
            chk("abort_quiet", {any_strobe, busy}, 0);
        end
        start_run(8'h05, 0);
        wait_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/worker_ctrl.md
# worker_ctrl

Sequencer for the partition worker datapath. On a start pulse it walks every vertex row of the current batch, fetches each row's Q vertex IDs from the VID SRAM, and issues one dist/loc SRAM read pair per sub-batch. It emits per-vertex accumulate strobes, aligned to the worker's pipeline depth, and commits next/pro results once per row. It sits between the batch-level top controller and one worker instance.

## Interface
- `Q`, 16: vertex IDs per VID row.
- `VID_BW`, 16: bits per vertex ID.
- `VID_ADDR_SPACE`, 4: VID row address width; ROWS = 2^VID_ADDR_SPACE.
- `SUB_BW`, 4: sub-batch index width; NSUB = 2^SUB_BW sub-batches per vertex.
- `DIST_ADDR_SPACE`, 16: dist address width, formed as {vid[DIST_ADDR_SPACE-SUB_BW-1:0], sub}.
- `LOC_ADDR_SPACE`, 4: loc address width; must equal SUB_BW.
- `NEXT_ADDR_SPACE`, 4 and `PRO_ADDR_SPACE`, 4: commit address widths; must equal VID_ADDR_SPACE.
- `PIPE_LAT`, 4: cycles from dist/loc address issue to the point where the worker consumes the strobes.
- `BATCH_BW`, 8: batch number width.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global advance enable.
- `start` in 1: one-cycle batch start request.
- `batch_num` in BATCH_BW: batch number, sampled on an accepted start.
- `vid_rdata` in Q*VID_BW: VID SRAM read data, one-cycle latency; vid[q] = vid_rdata[(Q-q)*VID_BW-1 -: VID_BW].
- `vid_ren`/`vid_raddr` out 1/VID_ADDR_SPACE: VID SRAM read request and address.
- `dist_ren`/`dist_raddr` out 1/DIST_ADDR_SPACE: dist SRAM read request and address.
- `loc_ren`/`loc_raddr` out 1/LOC_ADDR_SPACE: loc SRAM read request and address.
- `acc_clr` out 1: first sub-batch of a vertex, aligned to the worker.
- `acc_en` out 1: valid sub-batch, aligned to the worker.
- `acc_last` out 1: last sub-batch of a vertex, aligned to the worker.
- `acc_q` out 4: index (0..Q-1) of the vertex in flight, aligned to the worker.
- `next_wen`/`next_waddr` out 1/NEXT_ADDR_SPACE: next-partition row commit.
- `pro_wen`/`pro_waddr` out 1/PRO_ADDR_SPACE: progress row commit.
- `cur_batch` out BATCH_BW: batch number latched at start.
- `busy` out 1: high from the accepted start through the done cycle.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RD_VID, LAT_VID, SCAN, DRAIN, DONE.
- IDLE:
  - `start`=1 and `en`=1 → RD_VID.
  - On that transition: row←0, cur_batch←batch_num.
  - `start` in any other state is ignored.
- RD_VID: `vid_ren`=1, `vid_raddr`=row → LAT_VID.
- LAT_VID: capture vid[0..Q-1] from vid_rdata; q←0, sub←0 → SCAN.
- SCAN, one issue per cycle:
  - `dist_ren`=`loc_ren`=1.
  - `dist_raddr`={vid[q] low bits, sub}; `loc_raddr`=sub.
  - sub increments; on wrap NSUB-1→0, q increments.
  - After issuing (q=Q-1, sub=NSUB-1): if row<ROWS-1 → row+1, RD_VID; else → DRAIN.
- Issue tag pipeline: each SCAN issue pushes tag {valid, first=(sub==0), last=(sub==NSUB-1), q, row, row_end=(last && q==Q-1)}. The tag emerges PIPE_LAT enabled cycles later and drives:
  - `acc_en`=valid; `acc_clr`=valid&first; `acc_last`=valid&last; `acc_q`=q.
  - When row_end is set: `next_wen`=`pro_wen`=1, `next_waddr`=`pro_waddr`=tag.row.
- DRAIN: wait until the pipeline holds no valid tag → DONE.
- DONE: `done`=1 for one cycle → IDLE. `busy` drops in the following cycle.
- `en`=0:
  - FSM, counters, vid latch and tag pipeline all hold.
  - Every strobe (`*_ren`, `*_wen`, `acc_*` strobes, `done`) is forced to 0.
  - Address outputs hold their last values.
- `rst`=1, including mid-operation:
  - FSM returns to IDLE; the tag pipeline is cleared.
  - No commit and no `done` fire from the aborted batch.

## Timing
- Reset value of every output is 0.
- `vid_rdata` is valid in the cycle after `vid_ren`.
- Cycles per row: 2 + Q*NSUB (258 at defaults).
- First `dist_ren` occurs 3 cycles after the accepted start.
- Row r commits PIPE_LAT cycles after its final issue.
- `done` is high exactly ROWS*(2+Q*NSUB)+PIPE_LAT+1 enabled cycles after the start cycle (4133 at defaults).
- The row pipeline overlaps: row r+1's RD_VID/LAT_VID run while row r's tags are still in flight.
- A start in the same cycle as `done` is ignored. A start in the first IDLE cycle after `done` is accepted.

## Structure
- `graph_pkg` holds:
  - FSM state encoding.
  - The tag field layout.
  - Derived constants: ROWS, NSUB, DONE_CYCLES.
- Sub-module `ctrl_tag_pipe`: a PIPE_LAT-deep, en-gated shift register of tags with synchronous clear, plus a valid-occupancy flag used by DRAIN.

## Test plan
- Reset: hold `rst` for 3 cycles with random inputs → all outputs 0, `busy`=0; no strobe for 10 cycles after release.
- Address sequence: start with batch_num=8'h05 and row0 vid[q]=16'h0010+q.
  - First dist_raddr=16'h0100, then 16'h0101 … 16'h010F, then 16'h0110 …
  - loc_raddr cycles 0..15.
  - cur_batch=8'h05.
- Strobe alignment: `acc_clr` and the first `acc_en` occur PIPE_LAT cycles after the first dist_ren. `acc_last` pulses 16 times per row with acc_q=0..15.
- Commits: `next_wen`/`pro_wen` pulse 16 times with waddr 0..15. `done` fires at cycle 4133 after start, then `busy`=0.
- Stall: drop `en` for 10 cycles mid-SCAN at q=7, sub=3 → no strobes during the stall; the address sequence resumes unchanged; `done` arrives at cycle 4143.
- Abort and ignore: a start while busy is ignored. `rst` asserted mid-SCAN → no further commit or `done`. A fresh start then reproduces the full sequence from row 0.
